// File: rtl/reg_write_arbiter.sv
// Round-robin write-port arbiter for one datapath register.
// NREQ requesters share a registered WE/DOUT pair; a rotating pointer keeps grants fair.
module reg_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int CW   = 16
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic [NREQ-1:0]          REQ,
  input  logic [NREQ*DW-1:0]       REQ_DATA,
  input  logic                     HOLD,
  output logic [NREQ-1:0]          GNT,
  output logic                     WE,
  output logic [DW-1:0]            DOUT,
  output logic [$clog2(NREQ)-1:0]  OWNER,
  output logic [CW-1:0]            WR_COUNT
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] gnt_r;
  logic            we_r;
  logic [DW-1:0]   dout_r;
  logic [IW-1:0]   owner_r;
  logic [CW-1:0]   cnt_r;
  logic [IW-1:0]   ptr_r;

  logic [NREQ-1:0] elig_s;
  logic [IW-1:0]   idx_s;
  logic [IW-1:0]   sel_s;
  logic            found_s;
  logic            grant_s;
  logic [DW-1:0]   data_s;
  logic [NREQ-1:0] onehot_s;

  // Rotating priority search starting at ptr_r; the currently granted requester is masked.
  always_comb begin
    elig_s  = REQ & ~gnt_r;
    found_s = 1'b0;
    sel_s   = ptr_r;
    idx_s   = ptr_r;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = ptr_r + IW'(k);
      if (!found_s && elig_s[idx_s]) begin
        found_s = 1'b1;
        sel_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    grant_s  = found_s & ~HOLD;
    onehot_s = NREQ'(1) << sel_s;
  end

  // Data mux: only the selected slice can ever reach DOUT.
  always_comb begin
    data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_s == IW'(i)) begin
        data_s = REQ_DATA[i*DW +: DW];
      end else begin
        data_s = data_s;
      end
    end
  end

  // Grant/write registers; idle cycles clear GNT/WE and hold everything else.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      gnt_r   <= '0;
      we_r    <= 1'b0;
      dout_r  <= '0;
      owner_r <= '0;
      cnt_r   <= '0;
      ptr_r   <= '0;
    end else if (grant_s) begin
      gnt_r   <= onehot_s;
      we_r    <= 1'b1;
      dout_r  <= data_s;
      owner_r <= sel_s;
      cnt_r   <= cnt_r + CW'(1);
      ptr_r   <= sel_s + IW'(1);
    end else begin
      gnt_r   <= '0;
      we_r    <= 1'b0;
    end
  end

  assign GNT      = gnt_r;
  assign WE       = we_r;
  assign DOUT     = dout_r;
  assign OWNER    = owner_r;
  assign WR_COUNT = cnt_r;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter (NREQ=4, DW=32, CW=16).
module tb_reg_write_arbiter;

  logic         CLK;
  logic         RSTn;
  logic [3:0]   REQ;
  logic [127:0] REQ_DATA;
  logic         HOLD;
  logic [3:0]   GNT;
  logic         WE;
  logic [31:0]  DOUT;
  logic [1:0]   OWNER;
  logic [15:0]  WR_COUNT;

  int checks   = 0;
  int failures = 0;

  reg_write_arbiter #(.NREQ(4), .DW(32), .CW(16)) dut (
    .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .REQ_DATA(REQ_DATA), .HOLD(HOLD),
    .GNT(GNT), .WE(WE), .DOUT(DOUT), .OWNER(OWNER), .WR_COUNT(WR_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    REQ_DATA[i*32 +: 32] = v;
  endtask

  initial begin
    logic [31:0] d [4];
    d[0] = 32'hD000_0000; d[1] = 32'hD111_1111; d[2] = 32'hD222_2222; d[3] = 32'hD333_3333;
    RSTn = 1'b0; REQ = 4'b0000; HOLD = 1'b0; REQ_DATA = '0;
    for (int i = 0; i < 4; i++) set_data(i, d[i]);
    tick(); tick();
    RSTn = 1'b1;
    tick();
    chk("rst_gnt", 64'(GNT), 64'h0);
    chk("rst_we", 64'(WE), 64'h0);
    chk("rst_dout", 64'(DOUT), 64'h0);
    chk("rst_cnt", 64'(WR_COUNT), 64'h0);

    // Mid-run asynchronous reset with all requests pending
    REQ = 4'b1111;
    tick();
    chk("pre_rst_we", 64'(WE), 64'h1);
    #2 RSTn = 1'b0;
    #1;
    chk("arst_gnt", 64'(GNT), 64'h0);
    chk("arst_we", 64'(WE), 64'h0);
    chk("arst_dout", 64'(DOUT), 64'h0);
    chk("arst_cnt", 64'(WR_COUNT), 64'h0);
    chk("arst_owner", 64'(OWNER), 64'h0);
    tick();
    REQ = 4'b0001; set_data(0, 32'hA5A5_0001); RSTn = 1'b1;
    tick();
    chk("rel_gnt", 64'(GNT), 64'h1);
    chk("rel_we", 64'(WE), 64'h1);
    chk("rel_dout", 64'(DOUT), 64'hA5A5_0001);
    chk("rel_owner", 64'(OWNER), 64'h0);
    chk("rel_cnt", 64'(WR_COUNT), 64'h1);
    REQ = 4'b0000; set_data(0, d[0]);

    // Fresh reset, then round robin with drop-on-grant
    #2 RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    REQ = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_gnt", 64'(GNT), 64'(4'b0001 << i));
      chk("rr_dout", 64'(DOUT), 64'(d[i]));
      chk("rr_cnt", 64'(WR_COUNT), 64'(i + 1));
      REQ = REQ & ~GNT;
    end
    tick();
    chk("rr_idle_we", 64'(WE), 64'h0);
    chk("rr_idle_dout", 64'(DOUT), 64'(d[3]));

    // Rotation: grant 1 leaves PTR=2, then 1011 -> 3,0,1
    REQ = 4'b0010;
    tick();
    chk("rot_g1", 64'(GNT), 64'h2);
    REQ = 4'b1011;
    tick();
    chk("rot_o3", 64'(OWNER), 64'h3);
    REQ = REQ & ~GNT;
    tick();
    chk("rot_o0", 64'(OWNER), 64'h0);
    REQ = REQ & ~GNT;
    tick();
    chk("rot_o1", 64'(OWNER), 64'h1);
    chk("rot_cnt", 64'(WR_COUNT), 64'd8);
    REQ = 4'b0000;
    tick();

    // Masking: single requester held high gets every other cycle
    set_data(1, 32'h0000_0011);
    REQ = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mask_we", 64'(WE), (i % 2 == 0) ? 64'h1 : 64'h0);
      chk("mask_gnt", 64'(GNT), (i % 2 == 0) ? 64'h2 : 64'h0);
      chk("mask_dout", 64'(DOUT), 64'h11);
    end
    REQ = 4'b0000;
    tick();
    chk("mask_cnt", 64'(WR_COUNT), 64'd10);

    // HOLD blocks new grants; DOUT unchanged
    REQ = 4'b0100; HOLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_we", 64'(WE), 64'h0);
      chk("hold_dout", 64'(DOUT), 64'h11);
    end
    HOLD = 1'b0;
    tick();
    chk("hold_rel_gnt", 64'(GNT), 64'h4);
    chk("hold_rel_dout", 64'(DOUT), 64'(d[2]));
    chk("hold_rel_cnt", 64'(WR_COUNT), 64'd11);
    REQ = 4'b0000;

    // HOLD in the cycle a grant is already out does not cancel it; withdrawn request has no effect
    REQ = 4'b1000;
    tick();
    HOLD = 1'b1; REQ = 4'b0000;
    chk("hold_keep_we", 64'(WE), 64'h1);
    tick();
    HOLD = 1'b0;
    tick();
    chk("wdraw_we", 64'(WE), 64'h0);
    chk("wdraw_cnt", 64'(WR_COUNT), 64'd12);

    // Counter wrap: continuous 1111 grants one write per cycle
    REQ = 4'b1111;
    repeat (65523) tick();
    chk("wrap_pre_cnt", 64'(WR_COUNT), 64'hFFFF);
    chk("wrap_pre_we", 64'(WE), 64'h1);
    tick();
    chk("wrap_cnt", 64'(WR_COUNT), 64'h0);
    chk("wrap_we", 64'(WE), 64'h1);
    REQ = 4'b0000;
    tick();
    chk("wrap_idle_we", 64'(WE), 64'h0);
    chk("wrap_idle_cnt", 64'(WR_COUNT), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares the write port (WE/Data) of one 32-bit datapath register among NREQ requesters.
- Sits between producer blocks (ALU result, memory load path, immediate loader, debug/init path) and the register's CLK/WE/Data inputs.
- Registered outputs: WE and DOUT connect straight to the register.
- Reports which requester performed the last write and keeps a running write count.

Parameters:
- NREQ, 4, number of requesters; power of two, 2..8.
- DW, 32, data width of each request and of DOUT.
- CW, 16, width of the write counter.

Ports:
- CLK  input  1  rising-edge clock.
- RSTn  input  1  asynchronous, active-low reset.
- REQ  input  NREQ  per-requester write request; level, held until granted.
- REQ_DATA  input  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
- HOLD  input  1  when 1, no grant is issued this cycle (register is being read/frozen).
- GNT  output  NREQ  one-hot grant pulse, registered.
- WE  output  1  write enable to the register, registered.
- DOUT  output  DW  data to the register, registered.
- OWNER  output  log2(NREQ)  index of the most recently granted requester.
- WR_COUNT  output  CW  number of grants since reset.

Behaviour:
- Reset (RSTn=0, asynchronous): GNT=0, WE=0, DOUT=0, OWNER=0, WR_COUNT=0, internal pointer PTR=0. All pending requests are forgotten; no grant is issued in the first cycle after release unless REQ is sampled at that edge.
- Eligible set each cycle: E = REQ & ~GNT. A requester whose GNT is currently high is masked, so a requester that drops REQ on seeing GNT is never double-granted.
- Arbitration (combinational, sampled at the posedge):
  - If HOLD=0 and E≠0, sel = first index i with E[i]=1, searching PTR, PTR+1, … mod NREQ.
- Grant cycle (posedge with a valid sel):
  - GNT ← onehot(sel), WE ← 1, DOUT ← REQ_DATA[sel].
  - OWNER ← sel, PTR ← (sel+1) mod NREQ.
  - WR_COUNT ← WR_COUNT+1, wrapping from 2^CW−1 to 0.
- Idle cycle (HOLD=1 or E=0):
  - GNT ← 0, WE ← 0.
  - DOUT, OWNER, PTR and WR_COUNT hold their values.
- Latency: REQ sampled high at edge k produces WE/GNT high during cycle k→k+1. The register captures DOUT at edge k+1.
- Throughput: one write per cycle across requesters. A single continuously requesting requester gets at most one grant every 2 cycles, due to masking.
- Handshake: the requester holds REQ and its data stable until it samples GNT[i]=1, then may drop REQ or present new data with REQ still high. The next grant for that requester comes no earlier than 2 cycles later.
- HOLD asserted in the cycle a grant is already on the outputs does not cancel that grant; HOLD only blocks new grants.
- Simultaneous requests: exactly one grant per cycle; fairness is guaranteed by rotating PTR. Every requester holding REQ is granted within NREQ grant cycles.
- REQ dropped before grant: the request is withdrawn with no side effect.
- No X propagation: unused REQ_DATA slices are never routed to DOUT.

Test Plan:
- Reset: RSTn=0 mid-run with REQ=4'b1111 → outputs immediately 0 (GNT=0, WE=0, DOUT=0, WR_COUNT=0). After release with REQ=4'b0001, DATA0=32'hA5A5_0001 → one cycle later GNT=0001, WE=1, DOUT=A5A50001, OWNER=0.
- Round robin: REQ=4'b1111 held, requester drops REQ on its GNT → grant order 0,1,2,3 on consecutive cycles; WR_COUNT increments 1..4; DOUT follows DATA0..DATA3.
- Fairness with rotation: PTR=2 (after granting 1), REQ=4'b1011 → grant order 3, 0, 1.
- Masking: only REQ[1]=1 held continuously, DATA1=32'h0000_0011 → GNT/WE pattern 1,0,1,0…; DOUT=00000011 on each write.
- HOLD: REQ=4'b0100, HOLD=1 for 3 cycles → WE=0 and DOUT unchanged. Drop HOLD → grant 2 on the next edge.
- Counter wrap: preload via 65535 grants (or force) → next grant gives WR_COUNT=0x0000 with WE=1.
